fifo_serial_tx: RTL

Downstream drain stage for the 16x16 FIFO. When the FIFO is non-empty, it pops one word and sends it as an asynchronous serial frame on a single wire: start bit, 16 data bits LSB-first, optional even parity, stop bit. It then returns for the next word. It is the only reader of the FIFO and drives the FIFO's `read` input, so the FIFO's own `write` is never touched by this block.

---
 rtl/fifo_serial_tx_if.sv | 21 ++
 rtl/fifo_serial_tx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx_if.sv
// FIFO-drain / serial-line bundle between fifo_serial_tx and its environment.
// master is the transmitter side; slave is the FIFO plus line consumer.
interface fifo_serial_tx_if;
  logic        enable;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_rd;
  logic        tx_serial;
  logic        busy;
  logic        frame_done;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd, tx_serial, busy, frame_done
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd, tx_serial, busy, frame_done
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// Pops one 16-bit word from the FIFO and sends it as an async serial frame:
// start, 16 data bits LSB-first, optional even parity, stop.
module fifo_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input logic              clock,
  input logic              reset,
  fifo_serial_tx_if.master bus_io
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0] BaudPre  = BaudW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    StIdle, StRead, StFetch, StStart, StData, StParity, StStop
  } state_e;

  state_e            state_q;
  logic [BaudW-1:0]  baud_q;
  logic [3:0]        bit_cnt_q;
  logic [15:0]       shift_q;
  logic              parity_q;
  logic              fifo_rd_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              baud_last;

  assign baud_last = (baud_q == BaudLast);

  // Datapath has no reset: it is always reloaded in StFetch before use.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == StFetch) begin
        shift_q  <= bus_io.fifo_data;
        parity_q <= ^bus_io.fifo_data;
      end else if (state_q == StData && baud_last) begin
        shift_q <= {1'b0, shift_q[15:1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      fifo_rd_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fifo_rd_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (bus_io.enable && !bus_io.fifo_empty) begin
            fifo_rd_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StRead;
          end
        end
        // FIFO output becomes valid the cycle after the read strobe.
        StRead: state_q <= StFetch;
        StFetch: begin
          tx_q    <= 1'b0;
          state_q <= StStart;
        end
        StStart: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              if (PARITY_EN != 0) begin
                tx_q    <= parity_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StParity: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          tx_q <= 1'b1;
          if (baud_q == BaudPre) begin
            done_q <= 1'b1;
          end
          if (baud_last) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.fifo_rd    = fifo_rd_q;
  assign bus_io.tx_serial  = tx_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.frame_done = done_q;

endmodule
